grid_row_loader: RTL

// - Streams an ASCII grid (one byte/cycle, '\n'-terminated rows) into the banked `mem` array as DATA_W-bit

---
 rtl/grid_row_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/grid_row_loader.sv
// Packs a '\n'-terminated ASCII grid into DATA_W-bit occupancy chunks and writes them to banked mem.
// DATA_W must be a power of two below 2**COL_ADDR_W; LOADER_POPCOUNT_EN adds the count_out match counter.
module grid_row_loader #(
  parameter int          DATA_W     = 8,
  parameter int          ROW_ADDR_W = 8,
  parameter int          COL_ADDR_W = 6,
  parameter int          NUM_BANKS  = 1,
  parameter logic [7:0]  MATCH_CHAR = 8'h40,
  localparam int         LOG_B      = $clog2(NUM_BANKS),
  localparam int         BANK_W     = (NUM_BANKS > 1) ? LOG_B : 1,
  localparam int         ROWS_W     = ROW_ADDR_W + LOG_B,
  localparam int         COL_W      = COL_ADDR_W + 1
`ifdef LOADER_POPCOUNT_EN
  ,
  localparam int         CNT_W      = COL_ADDR_W + ROW_ADDR_W + LOG_B
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  char_valid,
  input  logic [7:0]            char_in,
  input  logic                  char_last,
  output logic                  char_ready,
  output logic                  write_en_out,
  output logic [BANK_W-1:0]     bank_sel_out,
  output logic [ROW_ADDR_W-1:0] row_addr_out,
  output logic [COL_ADDR_W-1:0] col_addr_out,
  output logic [DATA_W-1:0]     partial_vec_out,
  input  logic                  ack_in,
  output logic                  done_out,
  output logic [ROWS_W-1:0]     rows_out,
  output logic [COL_W-1:0]      cols_out,
  output logic                  error_out
`ifdef LOADER_POPCOUNT_EN
  ,
  output logic [CNT_W-1:0]      count_out
`endif
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int COL_MAX = 2 ** COL_ADDR_W;

  typedef enum logic [1:0] {ACCUM, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [DATA_W-1:0]     vec_q, vec_d;
  logic [ROWS_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]      cols_q, cols_d;
  logic                  first_q, first_d;
  logic                  error_q, error_d;
  logic                  eof_q, eof_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [ROW_ADDR_W-1:0] addr_q, addr_d;
  logic [COL_ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0]     data_q, data_d;
`ifdef LOADER_POPCOUNT_EN
  logic [CNT_W-1:0]      count_q, count_d;
`endif

  logic                  is_nl, is_cr, overflow, store, full, row_end, write_now;
  logic [COL_W-1:0]      col_n, col_m1;
  logic [DATA_W-1:0]     vec_n;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    vec_d     = vec_q;
    row_d     = row_q;
    cols_d    = cols_q;
    first_d   = first_q;
    error_d   = error_q;
    eof_d     = eof_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    base_d    = base_q;
    data_d    = data_q;
`ifdef LOADER_POPCOUNT_EN
    count_d   = count_q;
`endif
    is_nl     = (char_in == 8'h0A);
    is_cr     = (char_in == 8'h0D);
    overflow  = (col_q == COL_W'(COL_MAX));
    store     = 1'b0;
    full      = 1'b0;
    row_end   = 1'b0;
    write_now = 1'b0;
    col_n     = col_q;
    vec_n     = vec_q;
    col_m1    = col_q - COL_W'(1);

    case (state_q)
      ACCUM: begin
        if (char_valid) begin
          store = !is_nl && !is_cr && !overflow;
          if (!is_nl && !is_cr && overflow) error_d = 1'b1;
          if (store) begin
            vec_n[col_q[IDX_W-1:0]] = (char_in == MATCH_CHAR);
            col_n = col_q + COL_W'(1);
`ifdef LOADER_POPCOUNT_EN
            if (char_in == MATCH_CHAR) count_d = count_q + CNT_W'(1);
`endif
          end
          full      = store && (col_n[IDX_W-1:0] == '0);
          row_end   = (is_nl || char_last) && (col_n != '0);
          write_now = full || (row_end && (col_n[IDX_W-1:0] != '0));
          // Both a completed chunk and a flushed partial start at (col_n-1) rounded down to a chunk boundary.
          col_m1    = col_n - COL_W'(1);
          col_d     = col_n;
          vec_d     = full ? '0 : vec_n;

          if (write_now) begin
            bank_d = (NUM_BANKS > 1) ? row_q[BANK_W-1:0] : '0;
            addr_d = ROW_ADDR_W'(row_q >> LOG_B);
            base_d = COL_ADDR_W'(col_m1 & ~COL_W'(DATA_W - 1));
            data_d = vec_n;
          end

          if (row_end) begin
            row_d = row_q + ROWS_W'(1);
            col_d = '0;
            vec_d = '0;
            if (!first_q) begin
              first_d = 1'b1;
              cols_d  = col_n;
            end else if (col_n != cols_q) begin
              error_d = 1'b1;
            end
          end

          if (write_now) begin
            state_d = WRITE;
            eof_d   = char_last;
          end else if (char_last) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (ack_in) state_d = eof_q ? DONE : ACCUM;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      col_q   <= '0;
      vec_q   <= '0;
      row_q   <= '0;
      cols_q  <= '0;
      first_q <= 1'b0;
      error_q <= 1'b0;
      eof_q   <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
`ifdef LOADER_POPCOUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      vec_q   <= vec_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      first_q <= first_d;
      error_q <= error_d;
      eof_q   <= eof_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      data_q  <= data_d;
`ifdef LOADER_POPCOUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign char_ready      = (state_q == ACCUM);
  assign write_en_out    = (state_q == WRITE);
  assign done_out        = (state_q == DONE);
  assign bank_sel_out    = bank_q;
  assign row_addr_out    = addr_q;
  assign col_addr_out    = base_q;
  assign partial_vec_out = data_q;
  assign rows_out        = row_q;
  assign cols_out        = cols_q;
  assign error_out       = error_q;
`ifdef LOADER_POPCOUNT_EN
  assign count_out       = count_q;
`endif

endmodule
